uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmit line among `NREQ` byte requesters. It grants one requester at a time, latches its byte, and serializes an 11-bit frame: start, 8 data bits LSB first, odd parity, stop. It sits between the switch/button byte-loading front end, any echo or status sources, and the board `tx` pin, and replaces per-source ad-hoc transmit logic.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 10416: `clk` cycles per UART bit (100 MHz / 9600 baud); must be ≥2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input `NREQ`: request per source; held high with stable data until that source's `gnt`.
- `data` input `NREQ`×8: byte per source.
- `gnt` output `NREQ`: one-hot, single-cycle pulse on the cycle the byte is captured.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from capture through the end of the stop bit.
- `done` output 1: single-cycle pulse at the end of each stop bit.
- `last_src` output `$clog2(NREQ)`: index of the most recently granted source.

## Operation
- States: IDLE, SEND.
- IDLE: `tx`=1, `busy`=0. If any `req` is high on an edge:
  - Select the first set bit searching upward from `ptr+1`, wrapping modulo `NREQ`.
  - Capture `data[sel]` into the shift register `{1, ~^data, data, 0}` (bit 0 is shifted first).
  - Pulse `gnt[sel]`, set `ptr`=`last_src`=`sel`, set the baud counter to 0, and move to SEND.
- SEND:
  - `tx` = shift-register bit 0.
  - The baud counter counts 0..`CLKS_PER_BIT`-1. At the terminal count it clears, shifts right, and increments the bit count.
  - After the 11th bit's terminal count: `done`=1 for one cycle, `busy`=0, and the block returns to IDLE.
- Parity is odd: the number of 1s in data plus parity is odd.
- `req` is not sampled in SEND. A source may withdraw `req` before its grant with no effect. A withdrawn request is never granted.
- Reset values: `ptr`=`NREQ`-1 (source 0 has first priority), `tx`=1, `gnt`=0, `busy`=0, `done`=0, `last_src`=0, state IDLE.

## Timing
- All outputs are registered. There is no combinational path from `req`/`data` to any output.
- Grant latency: `req` high at edge k gives `gnt`, `busy`=1 and `tx`=0 (start bit) from edge k+1.
- Frame length: exactly 11×`CLKS_PER_BIT` cycles of `busy`=1.
- `done` rises on the same edge on which `busy` falls.
- Back-to-back: at least one IDLE cycle (`tx`=1) separates frames. With `req` held, the next start bit begins 1 cycle after `done`.
- Simultaneous requests: exactly one grant per frame, in round-robin order. With all `req` high, grants rotate 0,1,2,3,0,…
- `req` rising on the same edge as `done`: it is evaluated on the following IDLE edge.
- Reset mid-frame: the frame is aborted. `tx` goes to 1 immediately (asynchronous), with no `done` and no `gnt`.
- The bit count wraps only via the return to IDLE. Counters never overflow for legal `CLKS_PER_BIT`.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t` {IDLE, SEND};
  - `UART_FRAME_BITS`=11;
  - `UART_DATA_BITS`=8;
  - function `odd_parity(byte)` returning `~^byte`.
- Sub-module `uart_baud_gen`: parameterized counter with a synchronous `clr` input and a terminal-count `tick` output, reusable by the receive side.
- Round-robin select is a combinational function in the top module; it is not a separate module.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=4.
- Single byte: `req[0]`, `data[0]`=0xA5.
  - `gnt[0]` pulses 1 cycle after request.
  - `tx` bits (4 cycles each) 0,1,0,1,0,0,1,0,1,1,1.
  - `done` at cycle 45; `last_src`=0.
- Parity 0: `data[2]`=0x07 → parity bit 0, frame 0,1,1,1,0,0,0,0,0,0,1.
- Fairness: all four `req` held with distinct bytes, 8 frames.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each frame is 44 `busy` cycles with one IDLE cycle between frames.
- Withdraw/contention: `req[1]` and `req[3]` rise together, then `req[3]` drops during frame 1.
  - Only source 1 is granted; `tx` returns idle after `done`.
- Reset abort: `rst_n` low at cycle 20 of a frame.
  - `tx`=1 immediately, no `done`, `busy`=0.
  - After release, `req[2]` is granted first over a simultaneous `req[3]`, since `ptr` resets to 3.
- Late request: `req[1]` rises on the `done` edge.
  - The grant follows 1 IDLE cycle later, with no dropped or duplicated `gnt`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame geometry and the parity helper.
package uart_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } uart_tx_state_t;

  localparam int UART_FRAME_BITS = 11;
  localparam int UART_DATA_BITS  = 8;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [UART_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the shared UART transmitter: per-source request/byte in,
// grant pulse plus line and status flags out.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]                     req;
  logic [NREQ-1:0][UART_DATA_BITS-1:0] data;
  logic [NREQ-1:0]                     gnt;
  logic                                tx;
  logic                                busy;
  logic                                done;
  logic [SRC_W-1:0]                    last_src;

  modport master (
    output req, data,
    input  gnt, tx, busy, done, last_src
  );

  modport slave (
    input  req, data,
    output gnt, tx, busy, done, last_src
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Shared with the receive side, so it carries no UART framing knowledge.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART tx line among NREQ byte sources;
// sends start, 8 data bits LSB first, odd parity, stop.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);
  localparam int SRC_W = $clog2(NREQ);
  localparam int BIT_W = $clog2(UART_FRAME_BITS);

  uart_tx_state_t              state_reg, state_next;
  logic [SRC_W-1:0]            ptr_reg, ptr_next;
  logic [SRC_W-1:0]            last_src_reg, last_src_next;
  logic [UART_FRAME_BITS-1:0]  shift_reg, shift_next;
  logic [BIT_W-1:0]            bit_cnt_reg, bit_cnt_next;
  logic [NREQ-1:0]             gnt_reg, gnt_next;
  logic                        tx_reg, tx_next;
  logic                        busy_reg, busy_next;
  logic                        done_reg, done_next;

  logic [SRC_W-1:0]            sel;
  logic [NREQ-1:0]             sel_onehot;
  logic [UART_DATA_BITS-1:0]   sel_byte;
  logic                        tick;
  logic                        baud_clr;

  // First requester found searching upward from p+1, wrapping; scanning the
  // offsets downward lets the smallest offset win the final assignment.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [SRC_W-1:0] p);
    logic [SRC_W-1:0] idx;
    rr_pick = p;
    for (int i = NREQ; i >= 1; i--) begin
      idx = SRC_W'((int'(p) + i) % NREQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign sel      = rr_pick(bus.req, ptr_reg);
  assign sel_byte = bus.data[sel];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel == SRC_W'(gi));
  end

  // Counter is held at zero while idle so every frame starts on a full bit period.
  assign baud_clr = (state_reg == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= SRC_W'(NREQ - 1);
      last_src_reg <= '0;
      shift_reg    <= '1;
      bit_cnt_reg  <= '0;
      gnt_reg      <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      last_src_reg <= last_src_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      gnt_reg      <= gnt_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    last_src_next = last_src_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    gnt_next      = '0;
    tx_next       = tx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (|bus.req) begin
          shift_next    = {1'b1, odd_parity(sel_byte), sel_byte, 1'b0};
          gnt_next      = sel_onehot;
          ptr_next      = sel;
          last_src_next = sel;
          bit_cnt_next  = '0;
          busy_next     = 1'b1;
          tx_next       = 1'b0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          if (bit_cnt_reg == BIT_W'(UART_FRAME_BITS - 1)) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b1, shift_reg[UART_FRAME_BITS-1:1]};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            tx_next      = shift_reg[1];
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.gnt      = gnt_reg;
  assign bus.tx       = tx_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.last_src = last_src_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a frame-level model predicts each grant
// (source, byte, edge); an independent monitor decodes the line and compares.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ      = 4;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = UART_FRAME_BITS * CPB;

  typedef struct {
    int         src;
    logic [7:0] d;
    int         edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [NREQ-1:0] req_m;
  logic [NREQ-1:0] drop_m;
  logic [7:0] data_m[NREQ];
  int         ptr_m;
  int         next_free;
  int         last_grant;
  int         grants;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected line bits, built straight from the frame rules: start 0, data LSB first,
  // parity chosen so the count of ones over data+parity is odd, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic drive();
    bus.req = req_m;
    for (int i = 0; i < NREQ; i++) bus.data[i] = data_m[i];
  endtask

  // Frame-level model: the line is free again one idle cycle after an 11-bit frame.
  task automatic model_eval();
    int e = cyc + 1;
    int s = -1;
    int cand;
    if (rst_n && e >= next_free && req_m != '0) begin
      for (int off = 1; off <= NREQ; off++) begin
        cand = (ptr_m + off) % NREQ;
        if (s < 0 && req_m[cand]) s = cand;
      end
      exp_q.push_back('{src: s, d: data_m[s], edge_n: e});
      ptr_m      = s;
      drop_m[s]  = 1'b1;
      next_free  = e + FRAME_CYC + 1;
      last_grant = e;
      grants++;
    end
  endtask

  // mode 0: directed, 1: random raise/withdraw, 2: every granted source re-requests
  task automatic step(input int mode);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (drop_m[i]) begin
        req_m[i]  = 1'b0;
        drop_m[i] = 1'b0;
        if (mode == 2) begin
          req_m[i]  = 1'b1;
          data_m[i] = 8'($urandom);
        end
      end else if (mode == 1) begin
        if (!req_m[i] && $urandom_range(0, 99) < 6) begin
          req_m[i]  = 1'b1;
          data_m[i] = 8'($urandom);
        end else if (req_m[i] && $urandom_range(0, 999) < 4) begin
          req_m[i] = 1'b0;
        end
      end
    end
    drive();
    model_eval();
  endtask

  task automatic wait_quiet(input int bound);
    bit ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      step(0);
      if (req_m == '0 && drop_m == '0 && cyc + 1 >= next_free) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout actual=busy expected=idle within %0d cycles", bound);
    end
  endtask

  task automatic model_reset();
    req_m     = '0;
    drop_m    = '0;
    ptr_m     = NREQ - 1;
    next_free = 0;
    exp_q.delete();
    drive();
  endtask

  // Monitor: pops one expectation per grant and follows the whole frame on the line.
  initial begin
    exp_t       x;
    logic [10:0] got;
    logic [10:0] want;
    bit         stable;
    bit         aborted;
    int         busy_n;
    int         extra;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.gnt != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 32'(bus.gnt), 32'h0);
        end else begin
          x = exp_q.pop_front();
          check("gnt_src", 32'(bus.gnt), 32'(1) << x.src);
          check("gnt_edge", 32'(cyc), 32'(x.edge_n));
          check("last_src", 32'(bus.last_src), 32'(x.src));
          want    = ref_frame(x.d);
          got     = '0;
          stable  = 1'b1;
          aborted = 1'b0;
          busy_n  = 0;
          extra   = 0;
          for (int k = 0; k < FRAME_CYC; k++) begin
            if (k > 0) begin
              @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
            end
            if (k % CPB == 0) got[k/CPB] = bus.tx;
            else if (bus.tx !== got[k/CPB]) stable = 1'b0;
            if (bus.busy === 1'b1) busy_n++;
            if (k > 0 && bus.gnt != '0) extra++;
            if (bus.done !== 1'b0) extra++;
          end
          if (!aborted) begin
            checks++;
            if (got !== want) begin
              errors++;
              $display("FAIL frame src=%0d byte=%02h actual=%b expected=%b",
                       x.src, x.d, got, want);
            end
            check("bit_stable", 32'(stable), 32'd1);
            check("busy_cycles", 32'(busy_n), 32'(FRAME_CYC));
            check("mid_frame_pulses", 32'(extra), 32'd0);
            @(negedge clk);
            if (rst_n) begin
              check("done_cycle{done,busy,tx,gnt}",
                    {28'd0, bus.done, bus.busy, bus.tx, (bus.gnt != '0)}, 32'b1010);
            end
          end
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
          check("missed_gnt_src", 32'hFFFF_FFFF, 32'(exp_q[0].src));
          void'(exp_q.pop_front());
        end
        check("idle{tx,busy,done}", {29'd0, bus.tx, bus.busy, bus.done}, 32'b100);
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) data_m[i] = '0;
    grants = 0;
    last_grant = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset{tx,busy,done}", {29'd0, bus.tx, bus.busy, bus.done}, 32'b100);
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_last_src", 32'(bus.last_src), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: 1 beats 3, then 3 withdraws mid-frame and is never granted.
    req_m[1] = 1'b1; data_m[1] = 8'h3C;
    req_m[3] = 1'b1; data_m[3] = 8'hC3;
    repeat (10) step(0);
    req_m[3] = 1'b0;
    wait_quiet(200);

    // Single byte and zero-parity byte.
    req_m[0] = 1'b1; data_m[0] = 8'hA5;
    wait_quiet(200);
    req_m[2] = 1'b1; data_m[2] = 8'h07;
    wait_quiet(200);

    // Fairness: all sources keep requesting for 8 frames.
    req_m = '1;
    for (int i = 0; i < NREQ; i++) data_m[i] = 8'h10 * 8'(i + 1) + 8'h1;
    begin
      int g0 = grants;
      for (int n = 0; n < 8 * 60 && grants < g0 + 8; n++) step(2);
    end
    wait_quiet(400);

    // Late request: req[1] first visible on the done edge.
    req_m[0] = 1'b1; data_m[0] = 8'h5A;
    step(0);
    for (int n = 0; n < 100 && cyc + 2 < next_free - 1; n++) step(0);
    req_m[1] = 1'b1; data_m[1] = 8'h96;
    step(0);
    wait_quiet(200);

    // Reset abort 20 cycles into a frame, then 2 wins over 3 because ptr reset to 3.
    req_m[1] = 1'b1; data_m[1] = 8'hFF;
    step(0);
    for (int n = 0; n < 100 && cyc < last_grant + 20; n++) step(0);
    #2 rst_n = 1'b0;
    #1;
    check("abort{tx,busy,done}", {29'd0, bus.tx, bus.busy, bus.done}, 32'b100);
    check("abort_gnt", 32'(bus.gnt), 32'h0);
    check("abort_last_src", 32'(bus.last_src), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_m[2] = 1'b1; data_m[2] = 8'h81;
    req_m[3] = 1'b1; data_m[3] = 8'h00;
    drive();
    model_eval();
    wait_quiet(300);

    // Randomized traffic with occasional withdrawals.
    for (int n = 0; n < 3000; n++) step(1);
    wait_quiet(1000);
    repeat (5) step(0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
